asym_fifo_sdp_write_wider: RTL and testbench

Single-clock asymmetric FIFO. Each write is one wide word; each read returns one narrow word. Each wide word is split into RATIO narrow slices that are read out lowest slice first. It is the wide-in/narrow-out counterpart of the narrow-write/wide-read RAM in the same synthesis-example set, and it sits between a wide producer (e.g. a 16-bit datapath) and a narrow serial consumer. Storage is a simple-dual-port RAM of narrow words, intended to infer block or distributed RAM.

---
 rtl/asym_fifo_sdp_write_wider.sv | 105 ++++++++++
 tb/tb_asym_fifo_sdp_write_wider.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/asym_fifo_sdp_write_wider.sv
// Single-clock asymmetric FIFO: wide words in, narrow slices out.
// Each write lands RATIO slices at once; slice 0 is read out first.
module asym_fifo_sdp_write_wider #(
  parameter int WIDTHA     = 16,
  parameter int SIZEA      = 16,
  parameter int ADDRWIDTHA = 4,
  parameter int WIDTHB     = 4,
  parameter int SIZEB      = 64,
  parameter int ADDRWIDTHB = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  weA,
  input  logic [WIDTHA-1:0]     diA,
  output logic                  full,
  input  logic                  reB,
  output logic [WIDTHB-1:0]     doB,
  output logic                  doB_valid,
  output logic                  empty,
  output logic [ADDRWIDTHB:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int RATIO = WIDTHA / WIDTHB;
  localparam int LOG2R = $clog2(RATIO);
  localparam int LW    = ADDRWIDTHB + 1;

  localparam logic [LW-1:0] C_FULL = LW'(SIZEB - RATIO);
  localparam logic [LW-1:0] C_UP   = LW'(RATIO);
  localparam logic [LW-1:0] C_UP1  = LW'(RATIO - 1);
  localparam logic [LW-1:0] C_ONE  = LW'(1);

  logic [WIDTHB-1:0] r_ram [0:SIZEB-1];

  logic [ADDRWIDTHA:0] r_wp;
  logic [ADDRWIDTHB:0] r_rp;
  logic [LW-1:0]       r_level;
  logic [WIDTHB-1:0]   r_dob;
  logic                r_dob_valid;
  logic                r_ovf;
  logic                r_unf;

  logic w_full;
  logic w_empty;
  logic w_we;
  logic w_re;

  // Flags come from the level register only, so both requests see pre-edge state
  assign w_full  = (r_level > C_FULL);
  assign w_empty = (r_level == '0);
  assign w_we    = weA & ~w_full;
  assign w_re    = reB & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < RATIO; i++) begin
        r_ram[{r_wp[ADDRWIDTHA-1:0], LOG2R'(i)}] <=
          diA[i*WIDTHB +: WIDTHB];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_level     <= '0;
      r_dob       <= '0;
      r_dob_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_dob_valid <= w_re;
      if (w_re) begin
        r_dob <= r_ram[r_rp[ADDRWIDTHB-1:0]];
        r_rp  <= r_rp + 1'b1;
      end
      if (w_we) begin
        r_wp <= r_wp + 1'b1;
      end
      if (weA && w_full) begin
        r_ovf <= 1'b1;
      end
      if (reB && w_empty) begin
        r_unf <= 1'b1;
      end
      unique case ({w_we, w_re})
        2'b10:   r_level <= r_level + C_UP;
        2'b01:   r_level <= r_level - C_ONE;
        2'b11:   r_level <= r_level + C_UP1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = r_level;
  assign doB       = r_dob;
  assign doB_valid = r_dob_valid;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_asym_fifo_sdp_write_wider.sv
// Directed bench for asym_fifo_sdp_write_wider.
// A queue model of FIFO contents feeds an expected-output scoreboard.
module tb_asym_fifo_sdp_write_wider;

  logic        clk = 1'b0;
  logic        rst;
  logic        weA;
  logic [15:0] diA;
  logic        full;
  logic        reB;
  logic [3:0]  doB;
  logic        doB_valid;
  logic        empty;
  logic [6:0]  level;
  logic        overflow;
  logic        underflow;

  asym_fifo_sdp_write_wider dut (
    .clk       (clk),
    .rst       (rst),
    .weA       (weA),
    .diA       (diA),
    .full      (full),
    .reB       (reB),
    .doB       (doB),
    .doB_valid (doB_valid),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int        n_chk = 0;
  int        n_err = 0;
  logic [3:0] mq[$];
  logic [3:0] exq[$];
  logic       mov;
  logic       mun;
  logic [3:0] mdob;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_level"}, 32'(level), 32'(mq.size()));
    chk({tag, "_full"}, 32'(full), 32'(mq.size() > 60));
    chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, "_ovf"}, 32'(overflow), 32'(mov));
    chk({tag, "_unf"}, 32'(underflow), 32'(mun));
    chk({tag, "_dob"}, 32'(doB), 32'(mdob));
  endtask

  task automatic step(input logic we, input logic [15:0] d,
                      input logic re, input string tag);
    bit aw;
    bit ar;
    weA = we;
    diA = d;
    reB = re;
    aw = we && !(mq.size() > 60);
    ar = re && (mq.size() != 0);
    if (we && !aw) mov = 1'b1;
    if (re && !ar) mun = 1'b1;
    if (ar) exq.push_back(mq.pop_front());
    if (aw) for (int i = 0; i < 4; i++) mq.push_back(d[i*4 +: 4]);
    @(posedge clk);
    #1;
    weA = 1'b0;
    reB = 1'b0;
    chk({tag, "_valid"}, 32'(doB_valid), 32'(ar));
    if (ar && exq.size() > 0) mdob = exq.pop_front();
    chk_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    mq.delete();
    exq.delete();
    mov = 1'b0;
    mun = 1'b0;
    mdob = 4'h0;
    chk("rst_valid", 32'(doB_valid), 32'd0);
    chk_state("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 80 && mq.size() > 0; k++) step(1'b0, 16'h0, 1'b1, tag);
    chk({tag, "_drained"}, 32'(mq.size()), 32'd0);
  endtask

  int cnt;

  initial begin
    weA = 1'b0;
    reB = 1'b0;
    diA = 16'h0;
    rst = 1'b0;
    #1;
    do_reset();
    step(1'b0, 16'h0, 1'b0, "idle");

    step(1'b1, 16'hA5C3, 1'b0, "wr_a5c3");
    for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 1'b1, "rd_a5c3");
    chk("a5c3_last", 32'(doB), 32'hA);
    step(1'b0, 16'h0, 1'b0, "idle2");

    for (int k = 0; k < 16; k++) step(1'b1, 16'(k * 16'h1111 + 16'h0123), 1'b0, "fill");
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 16'hDEAD, 1'b0, "ovf_wr");
    chk("ovf_set", 32'(overflow), 32'd1);
    drain("drain64");

    step(1'b1, 16'h4321, 1'b0, "sim_pre");
    step(1'b1, 16'h8765, 1'b1, "sim4");
    chk("sim4_level", 32'(level), 32'd7);
    drain("drain_sim");

    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, 16'(k * 16'h0F1E + 16'h5A5A), 1'b0, "fill2");
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1, "to61");
    chk("l61_full", 32'(full), 32'd1);
    step(1'b1, 16'hBEEF, 1'b1, "sim61");
    chk("sim61_level", 32'(level), 32'd60);
    chk("sim61_ovf", 32'(overflow), 32'd1);
    drain("drain61");

    cnt = 0;
    for (int c = 0; c < 1000 && !(cnt == 40 && mq.size() == 0); c++) begin
      if (cnt < 40 && !(mq.size() > 60)) begin
        step(1'b1, 16'(cnt * 16'h0101 + 16'h1000), 1'b1, "wrap");
        cnt++;
      end else begin
        step(1'b0, 16'h0, 1'b1, "wrap");
      end
    end
    chk("wrap_done", 32'(cnt * 100 + mq.size()), 32'd4000);

    step(1'b0, 16'h0, 1'b1, "unf");
    chk("unf_set", 32'(underflow), 32'd1);

    step(1'b1, 16'h1234, 1'b0, "mid_wr");
    step(1'b0, 16'h0, 1'b1, "mid_rd");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(doB_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    do_reset();
    step(1'b0, 16'h0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
